// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Included by the top, the busy counter and any forwarding-mux owner.
package hazard_ctrl_pkg;

   localparam logic [1:0] TUSE_D    = 2'd0;
   localparam logic [1:0] TUSE_E    = 2'd1;
   localparam logic [1:0] TUSE_M    = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_NONE = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MULT = 2'b01,
      MD_DIV  = 2'b10,
      MD_ACC  = 2'b11
   } md_kind_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_M  = 2'b01;
   localparam logic [1:0] FWD_W  = 2'b10;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wa;
      logic [1:0] tnew;
      md_kind_t   md_kind;
   } e_stage_t;

   typedef struct packed {
      logic [4:0] rt;
      logic [4:0] wa;
      logic [1:0] tnew;
   } m_stage_t;

   // $0 is hard-wired, so it never participates in a hazard.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a == b) && (a != 5'd0);
   endfunction

   function automatic logic md_starts(input md_kind_t k);
      return (k == MD_MULT) || (k == MD_DIV);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wa_m,
                                          input logic [1:0] tnew_m, input logic [4:0] wa_w);
      if (reg_match(src, wa_m) && (tnew_m == TNEW_NONE)) begin
         return FWD_M;
      end else if (reg_match(src, wa_w)) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO busy tracker: loads on the edge a mult/div leaves E, then counts down.
module md_busy_counter
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     rst_n,
   input  md_kind_t kind_i,
   output logic     busy_o
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      unique case (kind_i)
         MD_MULT: cnt_d = CntW'(MULT_CYCLES);
         MD_DIV:  cnt_d = CntW'(DIV_CYCLES);
         default: begin
            if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The op sitting in E already owns the unit before the counter is loaded.
   assign busy_o = (cnt_q != '0) || md_starts(kind_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: E/M/W shadow pipeline, stall generation and forward selects.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [1:0] tuse_rs_d,
   input  logic [1:0] tuse_rt_d,
   input  logic [4:0] wa_d,
   input  logic [1:0] tnew_d,
   input  logic [1:0] md_kind_d,
   output logic [1:0] fwd_rs_d,
   output logic [1:0] fwd_rt_d,
   output logic [1:0] fwd_rs_e,
   output logic [1:0] fwd_rt_e,
   output logic       fwd_rt_m,
   output logic       stall,
   output logic       md_busy
);

   e_stage_t   e_d, e_q;
   m_stage_t   m_d, m_q;
   logic [4:0] wa_w_d, wa_w_q;

   logic stall_rs, stall_rt, stall_hilo;

   assign stall_rs = (tuse_rs_d != TUSE_NONE) &&
                     ((reg_match(rs_d, e_q.wa) && (e_q.tnew > tuse_rs_d)) ||
                      (reg_match(rs_d, m_q.wa) && (m_q.tnew > tuse_rs_d)));
   assign stall_rt = (tuse_rt_d != TUSE_NONE) &&
                     ((reg_match(rt_d, e_q.wa) && (e_q.tnew > tuse_rt_d)) ||
                      (reg_match(rt_d, m_q.wa) && (m_q.tnew > tuse_rt_d)));

   assign stall_hilo = (md_kind_t'(md_kind_d) != MD_NONE) && md_busy;
   assign stall      = stall_rs || stall_rt || stall_hilo;

   always_comb begin
      e_d = '{rs: rs_d, rt: rt_d, wa: wa_d, tnew: tnew_d, md_kind: md_kind_t'(md_kind_d)};
      // A bubble is an all-zero nop: no destination, no latency, no HI/LO use.
      if (stall) e_d = '0;
      m_d.rt   = e_q.rt;
      m_d.wa   = e_q.wa;
      m_d.tnew = (e_q.tnew != TNEW_NONE) ? e_q.tnew - 2'd1 : TNEW_NONE;
      wa_w_d   = m_q.wa;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q    <= '0;
         m_q    <= '0;
         wa_w_q <= '0;
      end else begin
         e_q    <= e_d;
         m_q    <= m_d;
         wa_w_q <= wa_w_d;
      end
   end

   assign fwd_rs_d = fwd_sel(rs_d, m_q.wa, m_q.tnew, wa_w_q);
   assign fwd_rt_d = fwd_sel(rt_d, m_q.wa, m_q.tnew, wa_w_q);
   assign fwd_rs_e = fwd_sel(e_q.rs, m_q.wa, m_q.tnew, wa_w_q);
   assign fwd_rt_e = fwd_sel(e_q.rt, m_q.wa, m_q.tnew, wa_w_q);
   assign fwd_rt_m = reg_match(m_q.rt, wa_w_q);

   md_busy_counter #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_busy_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .kind_i(e_q.md_kind),
      .busy_o(md_busy)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instruction-level pipeline model plus directed scenarios.
module tb_hazard_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] rs_d = '0, rt_d = '0, wa_d = '0;
   logic [1:0] tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, tnew_d = '0, md_kind_d = '0;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
   logic       fwd_rt_m, stall, md_busy;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_d     (rs_d),
      .rt_d     (rt_d),
      .tuse_rs_d(tuse_rs_d),
      .tuse_rt_d(tuse_rt_d),
      .wa_d     (wa_d),
      .tnew_d   (tnew_d),
      .md_kind_d(md_kind_d),
      .fwd_rs_d (fwd_rs_d),
      .fwd_rt_d (fwd_rt_d),
      .fwd_rs_e (fwd_rs_e),
      .fwd_rt_e (fwd_rt_e),
      .fwd_rt_m (fwd_rt_m),
      .stall    (stall),
      .md_busy  (md_busy)
   );

   always #5 clk = ~clk;

   // Model: instructions in flight, indexed 1 = E, 2 = M, 3 = W, with their original tnew.
   typedef struct {
      int rs;
      int rt;
      int wa;
      int tnew;
      int md;
   } instr_t;

   instr_t pipe [1:3];
   int     cyc;
   int     busy_until;

   function automatic bit mt(input int a, input int b);
      return (a == b) && (a != 0);
   endfunction

   // Cycles still needed before the result of the instruction in stage s exists.
   function automatic int rem(input int s);
      int r;
      r = pipe[s].tnew - (s - 1);
      return (r > 0) ? r : 0;
   endfunction

   function automatic bit m_busy();
      return (cyc <= busy_until) || (pipe[1].md == 1) || (pipe[1].md == 2);
   endfunction

   function automatic bit src_stall(input int r, input int t);
      if (t == 3) return 1'b0;
      for (int s = 1; s <= 2; s++) begin
         if (mt(r, pipe[s].wa) && (rem(s) > t)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      return src_stall(int'(rs_d), int'(tuse_rs_d)) || src_stall(int'(rt_d), int'(tuse_rt_d)) ||
             ((md_kind_d != 2'd0) && m_busy());
   endfunction

   function automatic int m_fwd(input int r);
      if (mt(r, pipe[2].wa) && (rem(2) == 0)) return 1;
      if (mt(r, pipe[3].wa)) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 1; s <= 3; s++) pipe[s] <= '{default: 0};
         cyc        <= 0;
         busy_until <= -1;
      end else begin
         cyc <= cyc + 1;
         if (pipe[1].md == 1) busy_until <= cyc + MC;
         else if (pipe[1].md == 2) busy_until <= cyc + DC;
         pipe[3] <= pipe[2];
         pipe[2] <= pipe[1];
         if (m_stall()) pipe[1] <= '{default: 0};
         else pipe[1] <= '{int'(rs_d), int'(rt_d), int'(wa_d), int'(tnew_d), int'(md_kind_d)};
      end
   end

   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      cmp("stall", int'(stall), int'(m_stall()));
      cmp("md_busy", int'(md_busy), int'(m_busy()));
      cmp("fwd_rs_d", int'(fwd_rs_d), m_fwd(int'(rs_d)));
      cmp("fwd_rt_d", int'(fwd_rt_d), m_fwd(int'(rt_d)));
      cmp("fwd_rs_e", int'(fwd_rs_e), m_fwd(pipe[1].rs));
      cmp("fwd_rt_e", int'(fwd_rt_e), m_fwd(pipe[1].rt));
      cmp("fwd_rt_m", int'(fwd_rt_m), int'(mt(pipe[2].rt, pipe[3].wa)));
   end

   task automatic drive(input int rs, input int trs, input int rt, input int trt, input int wa,
                        input int tnew, input int md);
      rs_d      = 5'(rs);
      tuse_rs_d = 2'(trs);
      rt_d      = 5'(rt);
      tuse_rt_d = 2'(trt);
      wa_d      = 5'(wa);
      tnew_d    = 2'(tnew);
      md_kind_d = 2'(md);
      #1;
   endtask

   task automatic nop();
      drive(0, 3, 0, 3, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      cmp({tag, ".stall"}, int'(stall), 0);
      cmp({tag, ".md_busy"}, int'(md_busy), 0);
      cmp({tag, ".fwd"}, int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
   endtask

   task automatic flush();
      nop();
      repeat (4) tick();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      nop();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 all_zero("reset");
      tick();
      all_zero("idle");

      // ALU dependency: addu $1 ; addu $7,$1,$6
      drive(4, 1, 5, 1, 1, 1, 0);
      tick();
      drive(1, 1, 6, 1, 7, 1, 0);
      cmp("alu.stall", int'(stall), 0);
      tick();
      cmp("alu.fwd_rs_e", int'(fwd_rs_e), 1);
      cmp("alu.stall_e", int'(stall), 0);
      flush();

      // Load-use to branch: lw $2 ; beq $2,$9
      drive(8, 1, 0, 3, 2, 2, 0);
      tick();
      drive(2, 0, 9, 0, 0, 0, 0);
      cmp("lub.stall1", int'(stall), 1);
      tick();
      cmp("lub.stall2", int'(stall), 1);
      tick();
      cmp("lub.stall3", int'(stall), 0);
      cmp("lub.fwd_rs_d", int'(fwd_rs_d), 2);
      flush();

      // Load then store data: lw $3 ; sw $3
      drive(8, 1, 0, 3, 3, 2, 0);
      tick();
      drive(10, 1, 3, 2, 0, 0, 0);
      cmp("ls.stall", int'(stall), 0);
      tick();
      nop();
      cmp("ls.fwd_rt_e", int'(fwd_rt_e), 0);
      tick();
      cmp("ls.fwd_rt_m", int'(fwd_rt_m), 1);
      flush();

      // mult then mflo: six stalled cycles, busy drops with stall
      drive(4, 1, 5, 1, 0, 0, 1);
      tick();
      drive(0, 3, 0, 3, 8, 1, 3);
      for (int i = 0; i < MC + 1; i++) begin
         cmp("mul.stall", int'(stall), 1);
         cmp("mul.busy", int'(md_busy), 1);
         tick();
      end
      cmp("mul.release", int'(stall), 0);
      cmp("mul.busy_end", int'(md_busy), 0);
      flush();

      // div then mflo: eleven stalled cycles
      drive(4, 1, 5, 1, 0, 0, 2);
      tick();
      drive(0, 3, 0, 3, 8, 1, 3);
      for (int i = 0; i < DC + 1; i++) begin
         cmp("div.stall", int'(stall), 1);
         tick();
      end
      cmp("div.release", int'(stall), 0);
      flush();

      // Zero register: lw $0 ; addu $5,$0,$0
      drive(8, 1, 0, 3, 0, 2, 0);
      tick();
      drive(0, 0, 0, 0, 5, 1, 0);
      all_zero("zero.d");
      tick();
      nop();
      all_zero("zero.e");
      flush();

      // Reset mid-divide, asserted between edges
      drive(4, 1, 5, 1, 0, 0, 2);
      tick();
      nop();
      repeat (3) tick();
      drive(0, 3, 0, 3, 8, 1, 3);
      cmp("rst.busy_pre", int'(md_busy), 1);
      cmp("rst.stall_pre", int'(stall), 1);
      #1 rst_n = 1'b0;
      #1;
      cmp("rst.busy_now", int'(md_busy), 0);
      cmp("rst.stall_now", int'(stall), 0);
      nop();
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         all_zero("rst.after");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
